data_mem_pipe: RTL and testbench
================================

// Module: data_mem_pipe
// PURPOSE
//  Parametrised byte-addressed big-endian data memory for the pipelined core, replacing the single-cycle Memory.
//  Handles byte/half/word loads and stores, with sign or zero extension on loads.
//  Valid/ready request and response handshakes; configurable read latency; misaligned accesses flagged, not silently aligned.
//  Sits between the MEM stage and the data-side bus; one request in, one in-order response out.
// PARAMETERS
//  ADDR_W  12  byte-address bits used; depth = 2**ADDR_W bytes
//  RD_LAT  1   request-to-response latency in cycles, legal 1..4
// PORTS
//  clk        in   1   clock; all state updates on posedge
//  rst        in   1   reset, synchronous, active-high
//  req_valid  in   1   request present
//  req_ready  out  1   request accepted when req_valid && req_ready
//  req_we     in   1   1 = store, 0 = load
//  req_size   in   2   00 byte, 01 half, 10 word, 11 illegal
//  req_sext   in   1   load sign-extend (1) / zero-extend (0)
//  req_addr   in   32  byte address; bits above ADDR_W-1 ignored (wraps)
//  req_wdata  in   32  store data, right-aligned (byte = [7:0], half = [15:0])
//  rsp_valid  out  1   response present
//  rsp_ready  in   1   response consumed when rsp_valid && rsp_ready
//  rsp_rdata  out  32  load data, extended; 0 for stores and errors
//  rsp_err    out  1   misaligned or illegal-size request
// BEHAVIOUR
//  - Reset: rsp_valid=0, rsp_rdata=0, rsp_err=0, all pipeline valid bits 0; memory array not cleared.
//  - Pipeline: RD_LAT-stage in-order shift; final stage drives rsp_*.
//    advance = !rsp_valid || rsp_ready; req_ready = advance (combinational); whole pipe stalls otherwise.
//  - Every accepted request, load or store, yields exactly one response RD_LAT cycles later, absent stalls.
//  - Stores: bytes written at the posedge of acceptance. Big-endian: word bytes go to A..A+3 as [31:24]..[7:0];
//    half bytes go to A, A+1 as [15:8], [7:0]; byte goes to A as [7:0]. Response carries rdata=0, err=0.
//  - Loads: array read at acceptance edge into stage 1. A store accepted on a cycle N is visible to any load accepted after cycle N.
//    Half: rdata = ext({M[A], M[A+1]}). Byte: rdata = ext(M[A]). ext = replicate bit 15/7 if req_sext, else zeros.
//  - Misaligned (half with A[0]=1, word with A[1:0]!=0) or req_size=11: no memory write; response err=1, rdata=0.
//  - Address wrap: word at 2**ADDR_W-4 is the last legal word; upper address bits are ignored, never an error.
//  - Back-to-back: one accept per cycle sustained while rsp_ready=1; a stall holds all stages and rsp_* stable.
//  - Reset mid-operation: in-flight loads are dropped with no response; stores already accepted remain committed.
// CONFIGURATION
//  MEM_STATS_EN defined: adds outputs stat_rd[31:0], stat_wr[31:0], stat_err[31:0].
//    Each counts accepted good loads, good stores, and errored requests respectively; updated on the accept edge.
//    Counters saturate at 0xFFFFFFFF and reset to 0 on rst.
//  MEM_STATS_EN undefined: those ports and counters are absent; all other behaviour is identical.
// TESTING
//  1 store word 0x80F01234 @0x20; load word @0x20 -> rdata 0x80F01234, err 0, exactly RD_LAT cycles after accept
//  2 after 1: lh sext @0x20 -> 0xFFFF80F0; lhu @0x22 -> 0x00001234; lb sext @0x21 -> 0xFFFFFFF0; lbu @0x23 -> 0x00000034
//  3 sh 0xABCD @0x31 -> err 1, bytes 0x30..0x33 unchanged; lw @0x22 -> err 1, rdata 0; req_size 11 -> err 1
//  4 issue 4 loads back-to-back, rsp_ready=0 for 3 cycles mid-stream -> req_ready=0 during stall, rsp_* held, 4 responses in order
//  5 sw 0x11223344 @(2**ADDR_W-4) and sw 0x55667788 @(2**ADDR_W+8) -> lw @0xFFC gives 0x11223344, lw @0x008 gives 0x55667788
//  6 rst high with 2 loads in flight -> rsp_valid 0 next cycle, no stale response; [MEM_STATS_EN] stat_* read 0

Source files
------------

// File: rtl/data_mem_pipe.sv
// Byte-addressed big-endian data memory with byte/half/word access, load extension and misalignment flagging.
// Latency: RD_LAT cycles from request accept to response (RD_LAT 1..4); optional MEM_STATS_EN adds access counters.
// Backpressure: the whole pipe advances only when the output slot is free or being consumed; req_ready mirrors that.
module data_mem_pipe #(
    parameter int ADDR_W = 12,
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_sext,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
`ifdef MEM_STATS_EN
    ,
    output logic [31:0] stat_rd,
    output logic [31:0] stat_wr,
    output logic [31:0] stat_err
`endif
);

    logic [7:0]        mem [0:(2**ADDR_W)-1];
    logic [ADDR_W-1:0] a0, a1, a2, a3;
    logic              advance, accept, bad, wr_en;
    logic [31:0]       ld_dat;

    logic [RD_LAT-1:0] stg_vld;
    logic [RD_LAT-1:0] stg_err;
    logic [31:0]       stg_dat [RD_LAT];

    // Upper address bits are deliberately ignored so accesses wrap.
    logic unused_addr;
    assign unused_addr = ^req_addr[31:ADDR_W];

    assign a0 = req_addr[ADDR_W-1:0];
    assign a1 = a0 + ADDR_W'(1);
    assign a2 = a0 + ADDR_W'(2);
    assign a3 = a0 + ADDR_W'(3);

    assign advance   = !rsp_valid || rsp_ready;
    assign req_ready = advance;
    assign accept    = req_valid && advance;

    always_comb begin
        bad = 1'b0;
        case (req_size)
            2'b01:   bad = a0[0];
            2'b10:   bad = (a0[1:0] != 2'b00);
            2'b11:   bad = 1'b1;
            default: bad = 1'b0;
        endcase
    end

    assign wr_en = accept && req_we && !bad;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            case (req_size)
                2'b00: mem[a0] <= req_wdata[7:0];
                2'b01: begin
                    mem[a0] <= req_wdata[15:8];
                    mem[a1] <= req_wdata[7:0];
                end
                default: begin
                    mem[a0] <= req_wdata[31:24];
                    mem[a1] <= req_wdata[23:16];
                    mem[a2] <= req_wdata[15:8];
                    mem[a3] <= req_wdata[7:0];
                end
            endcase
        end
    end

    always_comb begin
        ld_dat = '0;
        case (req_size)
            2'b00:   ld_dat = {{24{req_sext & mem[a0][7]}}, mem[a0]};
            2'b01:   ld_dat = {{16{req_sext & mem[a0][7]}}, mem[a0], mem[a1]};
            2'b10:   ld_dat = {mem[a0], mem[a1], mem[a2], mem[a3]};
            default: ld_dat = '0;
        endcase
        if (req_we || bad) begin
            ld_dat = '0;
        end
    end

    // Bubbles carry zero data so rsp_rdata is 0 whenever no response is presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            stg_vld <= '0;
            stg_err <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                stg_dat[i] <= '0;
            end
        end else if (advance) begin
            stg_vld[0] <= accept;
            stg_err[0] <= accept && bad;
            stg_dat[0] <= accept ? ld_dat : 32'h0;
            for (int i = 1; i < RD_LAT; i++) begin
                stg_vld[i] <= stg_vld[i-1];
                stg_err[i] <= stg_err[i-1];
                stg_dat[i] <= stg_dat[i-1];
            end
        end
    end

    assign rsp_valid = stg_vld[RD_LAT-1];
    assign rsp_err   = stg_err[RD_LAT-1];
    assign rsp_rdata = stg_dat[RD_LAT-1];

`ifdef MEM_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_rd  <= '0;
            stat_wr  <= '0;
            stat_err <= '0;
        end else if (accept) begin
            if (bad) begin
                if (stat_err != 32'hFFFF_FFFF) stat_err <= stat_err + 32'd1;
            end else if (req_we) begin
                if (stat_wr != 32'hFFFF_FFFF) stat_wr <= stat_wr + 32'd1;
            end else begin
                if (stat_rd != 32'hFFFF_FFFF) stat_rd <= stat_rd + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_data_mem_pipe.sv
// Directed self-checking bench for data_mem_pipe (ADDR_W=12, RD_LAT=2); MEM_STATS_EN optionally enables counter checks.
module tb_data_mem_pipe;

    localparam int AW  = 12;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_sext, rsp_valid, rsp_ready, rsp_err;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
`ifdef MEM_STATS_EN
    logic [31:0] stat_rd, stat_wr, stat_err;
`endif

    int checks = 0;
    int errors = 0;
    int n_rd = 0, n_wr = 0, n_err = 0;

    always #5 clk = ~clk;

    data_mem_pipe #(.ADDR_W(AW), .RD_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_sext(req_sext), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
`ifdef MEM_STATS_EN
        , .stat_rd(stat_rd), .stat_wr(stat_wr), .stat_err(stat_err)
`endif
    );

    // One request, wait for its response; returns data, error flag, edges from accept, timeout.
    task automatic xact(input logic we, input logic [1:0] size, input logic sext,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd, output logic er, output int lat, output bit to);
        int n;
        bit bad;
        req_valid = 1'b1; req_we = we; req_size = size; req_sext = sext;
        req_addr = addr; req_wdata = wdata; rsp_ready = 1'b1;
        #1;
        n = 0;
        while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
        bad = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
        if (bad) n_err++; else if (we) n_wr++; else n_rd++;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        rd = rsp_rdata; er = rsp_err; to = !rsp_valid;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_sext = 1'b0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata got %h want 0", rsp_rdata); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %b want 0", rsp_err); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_word();
        logic [31:0] rd; logic er; int lat; bit to;
        xact(1'b1, 2'b10, 1'b0, 32'h20, 32'h80F01234, rd, er, lat, to);
        checks++; if (to || er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL sw_rsp got rd=%h err=%b to=%0d want rd=0 err=0", rd, er, to); end
        checks++; if (lat != LAT) begin errors++; $display("FAIL sw_latency got %0d want %0d", lat, LAT); end
        xact(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er, lat, to);
        checks++; if (to || er !== 1'b0 || rd !== 32'h80F01234) begin errors++; $display("FAIL lw_0x20 got rd=%h err=%b want 80f01234 err=0", rd, er); end
        checks++; if (lat != LAT) begin errors++; $display("FAIL lw_latency got %0d want %0d", lat, LAT); end
    endtask

    task automatic test_subword();
        logic [31:0] rd; logic er; int lat; bit to;
        xact(1'b0, 2'b01, 1'b1, 32'h20, 32'h0, rd, er, lat, to);
        checks++; if (to || er !== 1'b0 || rd !== 32'hFFFF80F0) begin errors++; $display("FAIL lh_0x20 got %h want ffff80f0", rd); end
        xact(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, rd, er, lat, to);
        checks++; if (to || er !== 1'b0 || rd !== 32'h00001234) begin errors++; $display("FAIL lhu_0x22 got %h want 00001234", rd); end
        xact(1'b0, 2'b00, 1'b1, 32'h21, 32'h0, rd, er, lat, to);
        checks++; if (to || er !== 1'b0 || rd !== 32'hFFFFFFF0) begin errors++; $display("FAIL lb_0x21 got %h want fffffff0", rd); end
        xact(1'b0, 2'b00, 1'b0, 32'h23, 32'h0, rd, er, lat, to);
        checks++; if (to || er !== 1'b0 || rd !== 32'h00000034) begin errors++; $display("FAIL lbu_0x23 got %h want 00000034", rd); end
        xact(1'b1, 2'b00, 1'b0, 32'h24, 32'h000000A5, rd, er, lat, to);
        xact(1'b1, 2'b01, 1'b0, 32'h26, 32'h00007E01, rd, er, lat, to);
        xact(1'b0, 2'b10, 1'b0, 32'h24, 32'h0, rd, er, lat, to);
        checks++; if (to || rd[31:24] !== 8'hA5 || rd[15:0] !== 16'h7E01) begin errors++; $display("FAIL sb_sh_layout got %h want a5xx7e01", rd); end
    endtask

    task automatic test_misaligned();
        logic [31:0] rd; logic er; int lat; bit to;
        xact(1'b1, 2'b10, 1'b0, 32'h30, 32'hDEADBEEF, rd, er, lat, to);
        xact(1'b1, 2'b01, 1'b0, 32'h31, 32'h0000ABCD, rd, er, lat, to);
        checks++; if (to || er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL sh_misal got err=%b rd=%h want err=1 rd=0", er, rd); end
        xact(1'b1, 2'b11, 1'b0, 32'h30, 32'h12345678, rd, er, lat, to);
        checks++; if (to || er !== 1'b1) begin errors++; $display("FAIL st_size11 got err=%b want 1", er); end
        xact(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, rd, er, lat, to);
        checks++; if (to || er !== 1'b0 || rd !== 32'hDEADBEEF) begin errors++; $display("FAIL unchanged_0x30 got %h want deadbeef", rd); end
        xact(1'b0, 2'b10, 1'b0, 32'h22, 32'h0, rd, er, lat, to);
        checks++; if (to || er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL lw_misal got err=%b rd=%h want err=1 rd=0", er, rd); end
        xact(1'b0, 2'b11, 1'b1, 32'h20, 32'h0, rd, er, lat, to);
        checks++; if (to || er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL ld_size11 got err=%b rd=%h want err=1 rd=0", er, rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int lat; bit to;
        logic [31:0] vals [4];
        int sent, got;
        vals[0] = 32'hA0A0A0A0; vals[1] = 32'h0B0B0B0B; vals[2] = 32'hC0C0C0C0; vals[3] = 32'h0D0D0D0D;
        for (int k = 0; k < 4; k++) xact(1'b1, 2'b10, 1'b0, 32'h40 + 32'(4*k), vals[k], rd, er, lat, to);
        sent = 0; got = 0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            rsp_ready = !(c >= 3 && c < 6);
            req_valid = (sent < 4);
            req_we = 1'b0; req_size = 2'b10; req_sext = 1'b0;
            req_addr = 32'h40 + 32'(4*sent);
            #1;
            if (!rsp_ready) begin
                checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL stall_req_ready c=%0d got %b want 0", c, req_ready); end
                checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== vals[got]) begin errors++; $display("FAIL stall_hold c=%0d got v=%b %h want v=1 %h", c, rsp_valid, rsp_rdata, vals[got]); end
            end
            if (rsp_valid && rsp_ready) begin
                checks++; if (rsp_rdata !== vals[got] || rsp_err !== 1'b0) begin errors++; $display("FAIL b2b_order #%0d got %h want %h", got, rsp_rdata, vals[got]); end
                got++;
            end
            if (req_valid && req_ready) begin sent++; n_rd++; end
            @(posedge clk); #1;
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        checks++; if (got != 4) begin errors++; $display("FAIL b2b_count got %0d want 4", got); end
        @(posedge clk); #1;
    endtask

    task automatic test_wrap();
        logic [31:0] rd; logic er; int lat; bit to;
        xact(1'b1, 2'b10, 1'b0, 32'(2**AW - 4), 32'h11223344, rd, er, lat, to);
        checks++; if (to || er !== 1'b0) begin errors++; $display("FAIL sw_last err got %b want 0", er); end
        xact(1'b1, 2'b10, 1'b0, 32'(2**AW + 8), 32'h55667788, rd, er, lat, to);
        checks++; if (to || er !== 1'b0) begin errors++; $display("FAIL sw_wrap err got %b want 0", er); end
        xact(1'b0, 2'b10, 1'b0, 32'hFFC, 32'h0, rd, er, lat, to);
        checks++; if (to || er !== 1'b0 || rd !== 32'h11223344) begin errors++; $display("FAIL lw_0xffc got %h want 11223344", rd); end
        xact(1'b0, 2'b10, 1'b0, 32'h008, 32'h0, rd, er, lat, to);
        checks++; if (to || er !== 1'b0 || rd !== 32'h55667788) begin errors++; $display("FAIL lw_0x008 got %h want 55667788", rd); end
    endtask

`ifdef MEM_STATS_EN
    task automatic test_stats();
        checks++; if (stat_rd !== 32'(n_rd)) begin errors++; $display("FAIL stat_rd got %0d want %0d", stat_rd, n_rd); end
        checks++; if (stat_wr !== 32'(n_wr)) begin errors++; $display("FAIL stat_wr got %0d want %0d", stat_wr, n_wr); end
        checks++; if (stat_err !== 32'(n_err)) begin errors++; $display("FAIL stat_err got %0d want %0d", stat_err, n_err); end
    endtask
`endif

    task automatic test_reset_midflight();
        int seen;
        rsp_ready = 1'b1; req_we = 1'b0; req_size = 2'b10; req_sext = 1'b0;
        req_valid = 1'b1; req_addr = 32'h20;
        @(posedge clk); #1;
        req_addr = 32'h30;
        @(posedge clk); #1;
        req_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_flush got v=%b %h want v=0 0", rsp_valid, rsp_rdata); end
`ifdef MEM_STATS_EN
        checks++; if (stat_rd !== 32'h0 || stat_wr !== 32'h0 || stat_err !== 32'h0) begin errors++; $display("FAIL rst_stats got %0d %0d %0d want 0 0 0", stat_rd, stat_wr, stat_err); end
`endif
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (rsp_valid) seen++;
            @(posedge clk); #1;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL rst_stale got %0d responses want 0", seen); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_subword();
        test_misaligned();
        test_back_to_back();
        test_wrap();
`ifdef MEM_STATS_EN
        test_stats();
`endif
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
